// File: rtl/dmem_lsu.sv
// dmem_lsu: single-port byte-addressable data memory for the RV32I MEM stage.
// Stores write selected byte lanes of a 32-bit word. Loads return the selected
// bytes shifted down to bit 0 and then extended. DATA_OUT is registered and
// qualified by a one-cycle VALID_OUT. ERR pulses when an access is rejected.
module dmem_lsu #(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              VALID_OUT,
  output logic              ERR
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic              misaligned;
  logic              store_legal;
  logic              load_legal;
  logic              rd_err;
  logic              wr_err;
  logic              wr_en;
  logic [3:0]        byte_en;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_data;

  assign word_idx = ADDRESS[ADDR_W-1:2];
  assign lane     = ADDRESS[1:0];

  // Access decode: legality, alignment and lane enables. FUNCT3[1:0] is the size.
  always_comb begin
    misaligned  = ((FUNCT3[1:0] == 2'b01) && lane[0]) ||
                  ((FUNCT3[1:0] == 2'b10) && (lane != 2'b00));
    store_legal = (FUNCT3 == 3'b000) || (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010);
    load_legal  = (FUNCT3 != 3'b011) && (FUNCT3 != 3'b110) && (FUNCT3 != 3'b111);
    rd_err      = READ  && (WRITE || !load_legal  || misaligned);
    wr_err      = WRITE && (READ  || !store_legal || misaligned);
    wr_en       = WRITE && !wr_err;
    case (FUNCT3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
    // Replicating the narrow datum across the word puts it on every candidate
    // lane, so the byte enables alone select where it lands.
    case (FUNCT3[1:0])
      2'b00:   wr_data = {4{DATA_IN[7:0]}};
      2'b01:   wr_data = {2{DATA_IN[15:0]}};
      default: wr_data = DATA_IN;
    endcase
  end

  // Load path: asynchronous array read, lane shift, then sign or zero extension.
  always_comb begin
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (FUNCT3)
      3'b000:  ld_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'h000000, rd_shift[7:0]};
      3'b101:  ld_data = {16'h0000,   rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  // Array write with per-lane masking. The array has no reset, so its contents
  // survive a reset pulse, but stores are blocked while RESET_N is low.
  always_ff @(posedge CLK) begin
    if (RESET_N && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Output register. A reset discards any pending result. A rejected load
  // returns zero. DATA_OUT holds its value between loads.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DATA_OUT  <= 32'h0000_0000;
      VALID_OUT <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      VALID_OUT <= READ;
      ERR       <= rd_err || wr_err;
      if (READ) DATA_OUT <= rd_err ? 32'h0000_0000 : ld_data;
    end
  end

endmodule
